// File: rtl/snake_pkg.sv
// Shared snake-game definitions: arbiter states, requester slots, colour ids
// and the logical grid limits.
package snake_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE       = 2'd0,
      ARB_ISSUE_WAIT = 2'd1,
      ARB_ACK        = 2'd2
   } arb_state_e;

   localparam int REQ_CLEAR = 0;
   localparam int REQ_ERASE = 1;
   localparam int REQ_HEAD  = 2;
   localparam int REQ_APPLE = 3;

   localparam logic [7:0] COLOR_BG    = 8'h00;
   localparam logic [7:0] COLOR_BODY  = 8'h0f;
   localparam logic [7:0] COLOR_HEAD  = 8'hff;
   localparam logic [7:0] COLOR_APPLE = 8'hf9;

   localparam int         GRID_X_WIDTH = 5;
   localparam int         GRID_Y_WIDTH = 5;
   localparam logic [4:0] GRID_X_MAX   = 5'd31;
   localparam logic [4:0] GRID_Y_MAX   = 5'd23;

endpackage

// File: rtl/draw_req_picker.sv
// Combinational winner select for the draw arbiter: fixed priority (index 0
// first) or round-robin search starting at ptr when rr_mode is set.
module draw_req_picker
   import snake_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               rr_mode,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   int unsigned cand;

   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         // search offset k from the start point, wrapped into 0..NUM_REQ-1
         cand = k + (rr_mode ? 32'(ptr) : 32'd0);
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!valid && req[IDX_W'(cand)]) begin
            valid = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares the draw_superpixel write port between NUM_REQ drawers via req/ack.
// Define DRAW_ARB_RR_EN for round-robin selection; default is fixed priority.
module draw_request_arbiter
   import snake_pkg::*;
#(
   parameter int                 NUM_REQ     = 4,
   parameter int                 X_WIDTH     = GRID_X_WIDTH,
   parameter int                 Y_WIDTH     = GRID_Y_WIDTH,
   parameter logic [X_WIDTH-1:0] X_MAX       = X_WIDTH'(GRID_X_MAX),
   parameter logic [Y_WIDTH-1:0] Y_MAX       = Y_WIDTH'(GRID_Y_MAX),
   parameter int                 COLOR_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*X_WIDTH-1:0]     req_x,
   input  logic [NUM_REQ*Y_WIDTH-1:0]     req_y,
   input  logic [NUM_REQ*COLOR_WIDTH-1:0] req_color,
   output logic [NUM_REQ-1:0]             ack,
   output logic                           err,
   output logic [X_WIDTH-1:0]             px_x,
   output logic [Y_WIDTH-1:0]             px_y,
   output logic [COLOR_WIDTH-1:0]         px_data,
   output logic                           px_vld,
   input  logic                           px_done,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic [15:0]                    draw_count
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e               state_q, state_d;
   logic [NUM_REQ-1:0]       ack_q, ack_d;
   logic                     err_q, err_d;
   logic [X_WIDTH-1:0]       px_x_q, px_x_d;
   logic [Y_WIDTH-1:0]       px_y_q, px_y_d;
   logic [COLOR_WIDTH-1:0]   px_data_q, px_data_d;
   logic                     px_vld_q, px_vld_d;
   logic                     busy_q, busy_d;
   logic [IDX_W-1:0]         grant_q, grant_d;
   logic [15:0]              draw_count_q, draw_count_d;

   logic                     pick_valid;
   logic [IDX_W-1:0]         pick_idx;
   logic [IDX_W-1:0]         ptr;
   logic                     rr_mode;
   logic [X_WIDTH-1:0]       sel_x;
   logic [Y_WIDTH-1:0]       sel_y;
   logic [COLOR_WIDTH-1:0]   sel_color;
   logic                     sel_in_range;

`ifdef DRAW_ARB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   assign ptr     = ptr_q;
   assign rr_mode = 1'b1;

   // error acks advance the pointer too, so a bad requester cannot hog the port
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ARB_ACK) begin
         ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign ptr     = '0;
   assign rr_mode = 1'b0;
`endif

   draw_req_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req     (req),
      .ptr     (ptr),
      .rr_mode (rr_mode),
      .valid   (pick_valid),
      .index   (pick_idx)
   );

   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_color = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_x     = req_x[i*X_WIDTH +: X_WIDTH];
            sel_y     = req_y[i*Y_WIDTH +: Y_WIDTH];
            sel_color = req_color[i*COLOR_WIDTH +: COLOR_WIDTH];
         end
      end
      sel_in_range = (sel_x <= X_MAX) && (sel_y <= Y_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         ack_q        <= '0;
         err_q        <= 1'b0;
         px_x_q       <= '0;
         px_y_q       <= '0;
         px_data_q    <= '0;
         px_vld_q     <= 1'b0;
         busy_q       <= 1'b0;
         grant_q      <= '0;
         draw_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         px_x_q       <= px_x_d;
         px_y_q       <= px_y_d;
         px_data_q    <= px_data_d;
         px_vld_q     <= px_vld_d;
         busy_q       <= busy_d;
         grant_q      <= grant_d;
         draw_count_q <= draw_count_d;
      end
   end

   // px_vld_q marks the first ISSUE_WAIT cycle, where px_done is not trusted
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = sel_in_range ? ARB_ISSUE_WAIT : ARB_ACK;
            end
         end
         ARB_ISSUE_WAIT: begin
            if (!px_vld_q && px_done) begin
               state_d = ARB_ACK;
            end
         end
         ARB_ACK: state_d = ARB_IDLE;
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      ack_d        = '0;
      err_d        = 1'b0;
      px_vld_d     = 1'b0;
      px_x_d       = px_x_q;
      px_y_d       = px_y_q;
      px_data_d    = px_data_q;
      grant_d      = grant_q;
      draw_count_d = draw_count_q;
      busy_d       = (state_d != ARB_IDLE);
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               px_x_d    = sel_x;
               px_y_d    = sel_y;
               px_data_d = sel_color;
               grant_d   = pick_idx;
               if (sel_in_range) begin
                  px_vld_d = 1'b1;
               end else begin
                  ack_d[pick_idx] = 1'b1;
                  err_d           = 1'b1;
               end
            end
         end
         ARB_ISSUE_WAIT: begin
            if (!px_vld_q && px_done) begin
               ack_d[grant_q] = 1'b1;
            end
         end
         ARB_ACK: begin
            if (!err_q && (draw_count_q != 16'hFFFF)) begin
               draw_count_d = draw_count_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   assign ack        = ack_q;
   assign err        = err_q;
   assign px_x       = px_x_q;
   assign px_y       = px_y_q;
   assign px_data    = px_data_q;
   assign px_vld     = px_vld_q;
   assign busy       = busy_q;
   assign grant_id   = grant_q;
   assign draw_count = draw_count_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Self-checking bench for draw_request_arbiter: directed scenarios plus random
// traffic against a cycle-timeline reference model of the handshake.
module tb_draw_request_arbiter;
   import snake_pkg::*;

   localparam int N     = 4;
   localparam int XW    = 5;
   localparam int YW    = 5;
   localparam int CW    = 8;
   localparam int X_LIM = 31;
   localparam int Y_LIM = 23;
   localparam int INF   = 1 << 30;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*XW-1:0] req_x;
   logic [N*YW-1:0] req_y;
   logic [N*CW-1:0] req_color;
   logic [N-1:0]    ack;
   logic            err;
   logic [XW-1:0]   px_x;
   logic [YW-1:0]   px_y;
   logic [CW-1:0]   px_data;
   logic            px_vld;
   logic            px_done;
   logic            busy;
   logic [1:0]      grant_id;
   logic [15:0]     draw_count;

   always #5 clk = ~clk;

   draw_request_arbiter #(
      .NUM_REQ     (N),
      .X_WIDTH     (XW),
      .Y_WIDTH     (YW),
      .COLOR_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_color  (req_color),
      .ack        (ack),
      .err        (err),
      .px_x       (px_x),
      .px_y       (px_y),
      .px_data    (px_data),
      .px_vld     (px_vld),
      .px_done    (px_done),
      .busy       (busy),
      .grant_id   (grant_id),
      .draw_count (draw_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // timeline model: cycle numbers at which each observable event is due
   int         cyc = 0;
   int         vld_cycle, ack_cycle, idle_from;
   bit         outstanding;
   int         ack_id;
   bit         ack_err;
   int         g_id;
   logic [4:0] exp_x, exp_y;
   logic [7:0] exp_d;
   int         exp_count;
   int         ptr;

   bit auto_mode, hold_reqs;
   int done_mode, done_lat;
   int acks_seen[N];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input int x, input int y, input int c);
      req_x[i*XW +: XW]     = XW'(x);
      req_y[i*YW +: YW]     = YW'(y);
      req_color[i*CW +: CW] = CW'(c);
      req[i]                = 1'b1;
   endtask

   task automatic model_reset();
      vld_cycle   = -100;
      ack_cycle   = -100;
      outstanding = 1'b0;
      idle_from   = cyc + 1;
      g_id        = 0;
      exp_x       = '0;
      exp_y       = '0;
      exp_d       = '0;
      exp_count   = 0;
      ptr         = 0;
   endtask

   function automatic int pick_winner();
      int start = 0;
`ifdef DRAW_ARB_RR_EN
      start = ptr;
`endif
      for (int k = 0; k < N; k++)
         if (req[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   task automatic sample();
      @(negedge clk);
      cyc++;
      if ((cyc - 1 == ack_cycle) && !ack_err && exp_count != 16'hFFFF) exp_count++;
      check_val("ack", 32'(ack), (cyc == ack_cycle) ? (32'd1 << ack_id) : 32'd0);
      check_val("err", 32'(err), (cyc == ack_cycle) ? 32'(ack_err) : 32'd0);
      check_val("px_vld", 32'(px_vld), 32'(cyc == vld_cycle));
      check_val("busy", 32'(busy), 32'(cyc < idle_from));
      check_val("grant_id", 32'(grant_id), 32'(g_id));
      check_val("px_xyd", 32'({px_x, px_y, px_data}), 32'({exp_x, exp_y, exp_d}));
      check_val("draw_count", 32'(draw_count), 32'(exp_count));
      for (int i = 0; i < N; i++)
         if (ack[i]) acks_seen[i]++;
      if (cyc == ack_cycle) begin
         ptr = (ack_id + 1) % N;
         if (auto_mode && $urandom_range(0, 3) == 0)
            set_req(ack_id, $urandom_range(0, 31), $urandom_range(0, 27), $urandom_range(0, 255));
         else if (!hold_reqs)
            req[ack_id] = 1'b0;
      end
   endtask

   task automatic rand_reqs();
      for (int i = 0; i < N; i++)
         if (!req[i] && $urandom_range(0, 3) == 0)
            set_req(i, $urandom_range(0, 31), $urandom_range(0, 27), $urandom_range(0, 255));
   endtask

   task automatic commit();
      logic pd;
      int   w;
      pd = 1'b0;
      if (outstanding) begin
         case (done_mode)
            0:       pd = ($urandom_range(0, 2) == 0);
            1:       pd = (cyc == vld_cycle + done_lat);
            default: pd = (cyc == vld_cycle) || (cyc == vld_cycle + 3);
         endcase
      end
      px_done = pd;
      if (rst) begin
         model_reset();
         return;
      end
      if (outstanding && pd && cyc > vld_cycle) begin
         ack_cycle   = cyc + 1;
         ack_err     = 1'b0;
         ack_id      = g_id;
         idle_from   = cyc + 2;
         outstanding = 1'b0;
      end else if (!outstanding && cyc >= idle_from && req != '0) begin
         w     = pick_winner();
         g_id  = w;
         exp_x = req_x[w*XW +: XW];
         exp_y = req_y[w*YW +: YW];
         exp_d = req_color[w*CW +: CW];
         if (int'(exp_x) <= X_LIM && int'(exp_y) <= Y_LIM) begin
            vld_cycle   = cyc + 1;
            outstanding = 1'b1;
            idle_from   = INF;
         end else begin
            ack_cycle = cyc + 1;
            ack_err   = 1'b1;
            ack_id    = w;
            idle_from = cyc + 2;
         end
      end
   endtask

   task automatic step();
      sample();
      if (auto_mode) rand_reqs();
      commit();
   endtask

   task automatic run_until(input int who, input int need, input int budget);
      int start = acks_seen[who];
      int t = 0;
      while (acks_seen[who] < start + need && t < budget) begin
         step();
         t++;
      end
      check_val("phase_acks", 32'(acks_seen[who] - start), 32'(need));
   endtask

   task automatic drain(input int budget);
      int t = 0;
      hold_reqs = 1'b0;
      while ((req != '0 || busy || t < 2) && t < budget) begin
         step();
         t++;
      end
      check_val("drain", 32'(req != '0 || busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int d0, d3, base[N];
      bit hit;
      rst       = 1'b1;
      req       = '0;
      req_x     = '0;
      req_y     = '0;
      req_color = '0;
      px_done   = 1'b0;
      auto_mode = 1'b0;
      hold_reqs = 1'b0;
      done_mode = 1;
      done_lat  = 2;
      for (int i = 0; i < N; i++) acks_seen[i] = 0;
      model_reset();
      @(posedge clk);
      sample();
      rst = 1'b0;
      commit();
      step();

      // single head draw, odone four cycles after px_vld
      sample();
      done_lat = 4;
      set_req(REQ_HEAD, 5, 7, COLOR_HEAD);
      commit();
      run_until(REQ_HEAD, 1, 20);
      drain(20);
      check_val("count_after_single", 32'(draw_count), 32'd1);

      // all four at once
      sample();
      done_lat = 1;
      for (int i = 0; i < N; i++) begin
         base[i] = acks_seen[i];
         set_req(i, 2 * i, i + 1, 16 * i + 1);
      end
      commit();
      drain(80);
      for (int i = 0; i < N; i++)
         check_val("each_acked_once", 32'(acks_seen[i] - base[i]), 32'd1);

      // out of range apple
      sample();
      set_req(REQ_APPLE, 31, 24, COLOR_APPLE);
      commit();
      run_until(REQ_APPLE, 1, 10);
      drain(20);

      // reset pulse during ISSUE_WAIT, request held across it
      sample();
      done_lat = 10;
      set_req(REQ_ERASE, 10, 12, COLOR_BODY);
      commit();
      hit = 1'b0;
      for (int t = 0; t < 10 && !hit; t++) begin
         sample();
         if (outstanding && cyc == vld_cycle + 1) begin
            rst = 1'b1;
            hit = 1'b1;
         end
         commit();
      end
      check_val("rst_hit", 32'(hit), 32'd1);
      sample();
      rst = 1'b0;
      commit();
      run_until(REQ_ERASE, 1, 40);
      drain(20);

      // px_done coincident with px_vld must be ignored
      sample();
      done_mode = 2;
      set_req(REQ_CLEAR, 3, 4, COLOR_BG);
      commit();
      run_until(REQ_CLEAR, 1, 20);
      drain(20);

      // two requesters held high continuously
      sample();
      done_mode = 1;
      done_lat  = 1;
      hold_reqs = 1'b1;
      d0 = acks_seen[0];
      d3 = acks_seen[3];
      set_req(0, 1, 1, COLOR_BODY);
      set_req(3, 9, 9, COLOR_APPLE);
      commit();
      repeat (40) step();
      d0 = acks_seen[0] - d0;
      d3 = acks_seen[3] - d3;
`ifdef DRAW_ARB_RR_EN
      check_val("rr_fair", 32'((d0 - d3 <= 1) && (d3 - d0 <= 1) && d3 > 0), 32'd1);
`else
      check_val("fixed_starves", 32'(d3), 32'd0);
`endif
      drain(40);

      // random traffic with random odone latency
      auto_mode = 1'b1;
      done_mode = 0;
      repeat (3000) step();
      auto_mode = 1'b0;
      drain(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/draw_request_arbiter.md
# draw_request_arbiter

Shares the single `draw_superpixel` write port between up to NUM_REQ independent drawers: snake head, tail erase, apple and screen clear. Each requester presents a logical coordinate and a colour on a req/ack handshake. The arbiter picks one, issues a single-cycle `idata_vld` to `draw_superpixel`, waits for `odone`, then acknowledges the requester. It sits between the game logic (move/Apple) and `draw_superpixel` in the top level, and replaces the ad-hoc `pixel_vld` OR and colour muxing.

## Interface
- NUM_REQ, 4, number of requesters; index 0 is highest fixed priority
- X_WIDTH, 5, logical x width
- Y_WIDTH, 5, logical y width
- X_MAX, 5'd31, largest legal x
- Y_MAX, 5'd23, largest legal y
- COLOR_WIDTH, 8, colour id width
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_x  in  NUM_REQ*X_WIDTH  packed x; requester i uses bits [i*X_WIDTH +: X_WIDTH]
- req_y  in  NUM_REQ*Y_WIDTH  packed y, packed the same way as req_x
- req_color  in  NUM_REQ*COLOR_WIDTH  packed colour, packed the same way as req_x
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  valid with ack; 1 = request rejected (coordinate out of range)
- px_x  out  X_WIDTH  to draw_superpixel x
- px_y  out  Y_WIDTH  to draw_superpixel y
- px_data  out  COLOR_WIDTH  to draw_superpixel idata
- px_vld  out  1  to draw_superpixel idata_vld, one-cycle pulse
- px_done  in  1  from draw_superpixel odone
- busy  out  1  arbiter is not in IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant
- draw_count  out  16  saturating count of completed (non-error) draws

## Operation
- Requester rules:
  - Raise req with stable x/y/colour.
  - Hold all of them until ack.
  - Drop req in the ack cycle or later. A req still high in the cycle after ack starts a new request.
- State machine IDLE / ISSUE_WAIT / ACK:
  - IDLE: if any req=1, pick a winner, latch its x/y/colour and index into registers. Go to ISSUE_WAIT, or to ACK with err pending if the latched coordinate exceeds X_MAX/Y_MAX.
  - ISSUE_WAIT:
    - px_vld=1 in the first cycle only.
    - px_done is ignored in that first cycle.
    - On a later cycle with px_done=1, go to ACK.
  - ACK: ack[grant_id]=1 and err valid for exactly one cycle; then go to IDLE. In the ACK cycle, increment draw_count (saturating at 16'hFFFF) if err=0.
- Selection: fixed priority, lowest index wins (see Configuration for round-robin).
- px_x/px_y/px_data hold the latched values from grant until the next grant; they never change during ISSUE_WAIT.
- req from non-granted requesters is ignored while busy and stays pending.
- Reset values: ack=0, err=0, px_vld=0, px_x/px_y/px_data=0, busy=0, grant_id=0, draw_count=0, state IDLE.
- Reset mid-draw: the pending draw is abandoned and no ack is issued; requesters must re-request. draw_superpixel shares rst.

## Timing
- req rising at cycle t (state IDLE) gives px_vld=1 at t+1.
- px_done at cycle u ≥ t+2 gives ack=1 at u+1 and IDLE at u+2.
- Earliest next grant: arbitration at u+2, px_vld at u+3.
- Out-of-range request at t gives ack=1, err=1 at t+1, with no px_vld.
- Minimum handshake is 3 cycles for a valid draw. Throughput is bounded by draw_superpixel's odone latency.
- All outputs are registered. There is no combinational path from req or px_done to any output.

## Configuration
- DRAW_ARB_RR_EN defined: round-robin selection.
  - A pointer resets to 0.
  - Search order is ptr, ptr+1, … (mod NUM_REQ).
  - After each ack, ptr = grant_id+1 (mod NUM_REQ), including error acks.
- DRAW_ARB_RR_EN undefined: fixed priority, index 0 highest. No pointer register is generated.

## Structure
- Shared package `snake_pkg`:
  - state enum (ARB_IDLE, ARB_ISSUE_WAIT, ARB_ACK)
  - requester index constants: REQ_CLEAR=0, REQ_ERASE=1, REQ_HEAD=2, REQ_APPLE=3
  - colour constants: COLOR_BG=8'h00, COLOR_BODY=8'h0f, COLOR_HEAD=8'hff, COLOR_APPLE=8'hf9
  - logical-grid limits
- One sub-module, `draw_req_picker`: combinational winner select with inputs req, ptr and rr_mode, and outputs valid and index. It holds both fixed-priority and round-robin logic.

## Test plan
- Single request: req[2]=1, x=5, y=7, color=8'hff; bench returns px_done 4 cycles after px_vld → px_vld one cycle with px_x=5, px_y=7, px_data=8'hff; ack[2] one cycle after px_done; err=0; draw_count=1.
- Simultaneous req=4'b1111, fixed priority → grants occur in order 0,1,2,3, each acked exactly once; no overlap of px_vld with an outstanding draw.
- With DRAW_ARB_RR_EN, req[0] and req[3] held high continuously → grants alternate 0,3,0,3; neither requester is starved.
- Out of range: req[3]=1, x=31, y=24 → ack[3]=1 and err=1 on the next cycle; no px_vld; draw_count unchanged.
- rst pulsed one cycle during ISSUE_WAIT → next cycle busy=0, px_vld=0, draw_count=0, no ack; a held req is re-granted with px_vld 2 cycles after rst deasserts.
- px_done asserted in the same cycle as px_vld → ignored; ack only follows a later px_done.
